lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store control stage directly downstream of the AGU. Accepts aligned DTCM commands (addr, read, wdata,
//  wmask, itag, size, usign), issues them to the DTCM port, and tracks outstanding requests in an in-order FIFO.
//  Pairs responses with FIFO entries and aligns/extends load data. Writes back loads (data + itag) to the EXU,
//  and signals completion of every access on the AGU rsp channel.
// PARAMETERS
//  XLEN             32  datapath width (`XLEN)
//  DTCM_ADDR_WIDTH  16  DTCM byte-address width (`DTCM_ADDR_WIDTH)
//  ITAG_WIDTH        2  instruction tag width (`ITAG_WIDTH)
//  OUTS_DEPTH        2  max outstanding DTCM requests (power of 2, >=1)
// PORTS
//  clk              in   1      clock
//  rst_n            in   1      reset: synchronous, active-low
//  agu_cmd_valid    in   1      command valid from AGU
//  agu_cmd_ready    out  1      command accepted
//  agu_cmd_addr     in   DAW    byte address
//  agu_cmd_read     in   1      1=load 0=store
//  agu_cmd_wdata    in   XLEN   store data, pre-replicated by AGU
//  agu_cmd_wmask    in   XLEN/8 byte enables
//  agu_cmd_itag     in   ITW    instruction tag
//  agu_cmd_size     in   2      00=B 01=H 10=W
//  agu_cmd_usign    in   1      zero-extend load
//  agu_rsp_valid    out  1      access completed (load or store)
//  agu_rsp_ready    in   1      AGU accepts completion
//  dtcm_cmd_valid   out  1      DTCM request valid
//  dtcm_cmd_ready   in   1      DTCM accepts request
//  dtcm_cmd_addr    out  DAW    = agu_cmd_addr
//  dtcm_cmd_read    out  1      = agu_cmd_read
//  dtcm_cmd_wdata   out  XLEN   = agu_cmd_wdata
//  dtcm_cmd_wmask   out  XLEN/8 = agu_cmd_wmask (forced 0 on loads)
//  dtcm_rsp_valid   in   1      DTCM response valid
//  dtcm_rsp_ready   out  1      response consumed
//  dtcm_rsp_rdata   in   XLEN   raw word read data
//  dtcm_rsp_err     in   1      bus error
//  lsu_o_valid      out  1      load writeback valid
//  lsu_o_ready      in   1      writeback accepted
//  lsu_o_wbck_wdat  out  XLEN   aligned, extended load data
//  lsu_o_wbck_itag  out  ITW    tag of the load
//  lsu_o_wbck_err   out  1      DTCM error on this load
// BEHAVIOUR
//  Reset: FIFO empty; all outputs 0 except dtcm_rsp_ready=1 (drain/discard stale responses).
//  Issue (combinational pass-through, 0 cycles): dtcm_cmd_valid = agu_cmd_valid & ~full;
//   agu_cmd_ready = dtcm_cmd_ready & ~full. Push {itag,read,size,usign,addr[1:0]} on agu cmd handshake.
//  Full: no push even if a pop occurs in the same cycle (no bypass); empty: no response is paired.
//  Response: head entry h. Load: lsu_o_valid = dtcm_rsp_valid & ~empty; dtcm_rsp_ready = lsu_o_ready & agu_rsp_ready.
//   Store: lsu_o_valid=0; dtcm_rsp_ready = agu_rsp_ready. agu_rsp_valid = dtcm_rsp_valid & ~empty & (h.read ? lsu_o_ready : 1).
//   Pop on dtcm_rsp handshake with ~empty. Empty: dtcm_rsp_ready=1, response dropped, no outputs raised.
//  Simultaneous push and pop: both occur; count unchanged; pointers each advance and wrap mod OUTS_DEPTH.
//  Load data: sh = rdata >> (8*h.addr[1:0]); B: ext(sh[7:0]); H: ext(sh[15:0]); W: rdata. ext = zero if usign else sign.
//  Error: lsu_o_wbck_err = dtcm_rsp_err for loads; store errors are ignored (completion still signalled).
//  AGU guarantees natural alignment; misaligned commands are an assertion failure, not handled.
//  Ordering: strictly in-order; DTCM must respond in request order.
//  Reset mid-operation: outstanding entries discarded; subsequent responses drained per the empty rule.
// STRUCTURE
//  Shared defines: `XLEN, `DTCM_ADDR_WIDTH, `ITAG_WIDTH, size encodings LSU_SIZE_B/H/W, entry width macro.
//  One sub-module: lsu_outs_fifo (parameterised depth/width sync FIFO, full/empty, sync active-low reset).
//  Top: issue logic, response pairing, load align/extend mux.
// TESTING
//  1. Store SW addr 0x10 data 0xDEADBEEF -> dtcm_cmd wmask 4'b1111 same cycle; on rsp agu_rsp_valid=1, lsu_o_valid=0.
//  2. LB addr 0x3, rdata 0x80xxxxxx, usign=0 -> wdat 0xFFFFFF80; LBU -> 0x00000080; itag echoed.
//  3. LH addr 0x2, rdata 0x8001_xxxx -> 0xFFFF8001; LHU -> 0x00008001.
//  4. Issue OUTS_DEPTH loads with no rsp -> agu_cmd_ready=0; one rsp + new cmd same cycle -> pop only, push next cycle.
//  5. lsu_o_ready=0 with dtcm_rsp_valid on a load -> dtcm_rsp_ready=0, entry held; raise ready -> single writeback.
//  6. rst_n low with 2 outstanding, then stale rsp -> dtcm_rsp_ready=1, no lsu_o_valid/agu_rsp_valid; err on load -> lsu_o_wbck_err=1.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl_pkg
//  Brief    : Shared widths, access-size encodings and outstanding-entry layout
//             for the load/store control stage.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_ctrl_pkg;

    localparam int c_XLEN            = 32;
    localparam int c_DTCM_ADDR_WIDTH = 16;
    localparam int c_ITAG_WIDTH      = 2;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'b00,
        LSU_SIZE_H = 2'b01,
        LSU_SIZE_W = 2'b10
    } lsu_size_e;

    // Entry layout, LSB first: byte offset[1:0], usign[2], size[4:3], read[5], itag[6+].
    localparam int c_ENT_OFF_LSB   = 0;
    localparam int c_ENT_USIGN_BIT = 2;
    localparam int c_ENT_SIZE_LSB  = 3;
    localparam int c_ENT_READ_BIT  = 5;
    localparam int c_ENT_ITAG_LSB  = 6;

    function automatic int lsu_entry_width(input int itag_width);
        return itag_width + c_ENT_ITAG_LSB;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_outs_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_outs_fifo
//  Brief    : Synchronous FIFO tracking outstanding DTCM requests in issue order.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_outs_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_W'(DEPTH - 1)) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    assign o_full     = (r_count == c_CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    // No bypass: a full FIFO refuses a push even when a pop frees a slot this cycle.
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop & ~o_empty;
    assign o_pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl
//  Brief    : Load/store control stage: issues AGU commands to the DTCM, pairs
//             in-order responses, aligns/extends load data, signals completion.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN            = c_XLEN,
    parameter int DTCM_ADDR_WIDTH = c_DTCM_ADDR_WIDTH,
    parameter int ITAG_WIDTH      = c_ITAG_WIDTH,
    parameter int OUTS_DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       agu_cmd_valid,
    output logic                       agu_cmd_ready,
    input  logic [DTCM_ADDR_WIDTH-1:0] agu_cmd_addr,
    input  logic                       agu_cmd_read,
    input  logic [XLEN-1:0]            agu_cmd_wdata,
    input  logic [XLEN/8-1:0]          agu_cmd_wmask,
    input  logic [ITAG_WIDTH-1:0]      agu_cmd_itag,
    input  logic [1:0]                 agu_cmd_size,
    input  logic                       agu_cmd_usign,
    output logic                       agu_rsp_valid,
    input  logic                       agu_rsp_ready,
    output logic                       dtcm_cmd_valid,
    input  logic                       dtcm_cmd_ready,
    output logic [DTCM_ADDR_WIDTH-1:0] dtcm_cmd_addr,
    output logic                       dtcm_cmd_read,
    output logic [XLEN-1:0]            dtcm_cmd_wdata,
    output logic [XLEN/8-1:0]          dtcm_cmd_wmask,
    input  logic                       dtcm_rsp_valid,
    output logic                       dtcm_rsp_ready,
    input  logic [XLEN-1:0]            dtcm_rsp_rdata,
    input  logic                       dtcm_rsp_err,
    output logic                       lsu_o_valid,
    input  logic                       lsu_o_ready,
    output logic [XLEN-1:0]            lsu_o_wbck_wdat,
    output logic [ITAG_WIDTH-1:0]      lsu_o_wbck_itag,
    output logic                       lsu_o_wbck_err
);

    localparam int c_ENTRY_W = lsu_entry_width(ITAG_WIDTH);

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [c_ENTRY_W-1:0]  w_push_entry;
    logic [c_ENTRY_W-1:0]  w_head_entry;
    logic [ITAG_WIDTH-1:0] w_head_itag;
    logic                  w_head_read;
    lsu_size_e             w_head_size;
    logic                  w_head_usign;
    logic [1:0]            w_head_off;
    logic                  w_head_is_load;
    logic [XLEN-1:0]       w_shifted;
    logic [XLEN-1:0]       w_load_data;

    // ---------------- issue path ----------------
    assign dtcm_cmd_valid = agu_cmd_valid & ~w_full;
    assign agu_cmd_ready  = dtcm_cmd_ready & ~w_full;
    assign dtcm_cmd_addr  = agu_cmd_addr;
    assign dtcm_cmd_read  = agu_cmd_read;
    assign dtcm_cmd_wdata = agu_cmd_wdata;
    assign dtcm_cmd_wmask = agu_cmd_read ? '0 : agu_cmd_wmask;
    assign w_push         = agu_cmd_valid & agu_cmd_ready;
    assign w_push_entry   = {agu_cmd_itag, agu_cmd_read, agu_cmd_size, agu_cmd_usign, agu_cmd_addr[1:0]};

    lsu_outs_fifo #(
        .DEPTH (OUTS_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_outs_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_pop_data  (w_head_entry),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // ---------------- response pairing ----------------
    assign w_head_off     = w_head_entry[c_ENT_OFF_LSB +: 2];
    assign w_head_usign   = w_head_entry[c_ENT_USIGN_BIT];
    assign w_head_size    = lsu_size_e'(w_head_entry[c_ENT_SIZE_LSB +: 2]);
    assign w_head_read    = w_head_entry[c_ENT_READ_BIT];
    assign w_head_itag    = w_head_entry[c_ENT_ITAG_LSB +: ITAG_WIDTH];
    assign w_head_is_load = ~w_empty & w_head_read;

    // With nothing outstanding, stale responses are accepted and dropped.
    always_comb begin
        dtcm_rsp_ready = 1'b1;
        if (!w_empty) begin
            dtcm_rsp_ready = w_head_read ? (lsu_o_ready & agu_rsp_ready) : agu_rsp_ready;
        end
    end

    assign w_pop         = dtcm_rsp_valid & dtcm_rsp_ready & ~w_empty;
    assign lsu_o_valid   = dtcm_rsp_valid & w_head_is_load;
    assign agu_rsp_valid = dtcm_rsp_valid & ~w_empty & (~w_head_read | lsu_o_ready);

    // ---------------- load align / extend ----------------
    assign w_shifted = dtcm_rsp_rdata >> {w_head_off, 3'b000};

    always_comb begin
        w_load_data = dtcm_rsp_rdata;
        case (w_head_size)
            LSU_SIZE_B: w_load_data = {{(XLEN-8){~w_head_usign & w_shifted[7]}}, w_shifted[7:0]};
            LSU_SIZE_H: w_load_data = {{(XLEN-16){~w_head_usign & w_shifted[15]}}, w_shifted[15:0]};
            default:    w_load_data = dtcm_rsp_rdata;
        endcase
    end

    assign lsu_o_wbck_wdat = lsu_o_valid ? w_load_data  : '0;
    assign lsu_o_wbck_itag = lsu_o_valid ? w_head_itag  : '0;
    assign lsu_o_wbck_err  = lsu_o_valid ? dtcm_rsp_err : 1'b0;

    // The AGU only ever presents naturally aligned accesses.
    always @(posedge clk) begin
        if (rst_n && w_push) begin
            assert (!((agu_cmd_size == LSU_SIZE_H && agu_cmd_addr[0]) ||
                      (agu_cmd_size == LSU_SIZE_W && agu_cmd_addr[1:0] != 2'b00)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_ctrl
//  Brief    : Directed self-checking bench for lsu_ctrl with a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

    localparam int c_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        agu_cmd_valid, agu_cmd_ready;
    logic [15:0] agu_cmd_addr;
    logic        agu_cmd_read;
    logic [31:0] agu_cmd_wdata;
    logic [3:0]  agu_cmd_wmask;
    logic [1:0]  agu_cmd_itag;
    logic [1:0]  agu_cmd_size;
    logic        agu_cmd_usign;
    logic        agu_rsp_valid, agu_rsp_ready;
    logic        dtcm_cmd_valid, dtcm_cmd_ready;
    logic [15:0] dtcm_cmd_addr;
    logic        dtcm_cmd_read;
    logic [31:0] dtcm_cmd_wdata;
    logic [3:0]  dtcm_cmd_wmask;
    logic        dtcm_rsp_valid, dtcm_rsp_ready;
    logic [31:0] dtcm_rsp_rdata;
    logic        dtcm_rsp_err;
    logic        lsu_o_valid, lsu_o_ready;
    logic [31:0] lsu_o_wbck_wdat;
    logic [1:0]  lsu_o_wbck_itag;
    logic        lsu_o_wbck_err;

    lsu_ctrl #(.OUTS_DEPTH(c_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready),
        .agu_cmd_addr(agu_cmd_addr), .agu_cmd_read(agu_cmd_read),
        .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_wmask(agu_cmd_wmask),
        .agu_cmd_itag(agu_cmd_itag), .agu_cmd_size(agu_cmd_size),
        .agu_cmd_usign(agu_cmd_usign),
        .agu_rsp_valid(agu_rsp_valid), .agu_rsp_ready(agu_rsp_ready),
        .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready),
        .dtcm_cmd_addr(dtcm_cmd_addr), .dtcm_cmd_read(dtcm_cmd_read),
        .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
        .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready),
        .dtcm_rsp_rdata(dtcm_rsp_rdata), .dtcm_rsp_err(dtcm_rsp_err),
        .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready),
        .lsu_o_wbck_wdat(lsu_o_wbck_wdat), .lsu_o_wbck_itag(lsu_o_wbck_itag),
        .lsu_o_wbck_err(lsu_o_wbck_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int wb_count = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int tag;
        bit is_load;
        int nbytes;
        int offset;
        bit usign;
    } access_t;

    access_t outstanding[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected load writeback value from the raw word, access width and byte offset.
    function automatic logic [31:0] model_load(input logic [31:0] rdata, input int nbytes,
                                               input int offset, input bit usign);
        longint unsigned span, v;
        span = 64'd1 << (8 * nbytes);
        v    = (longint'(rdata) / (64'd1 << (8 * offset))) % span;
        if (!usign && nbytes < 4 && v >= span / 2) v = v + (64'd1 << 32) - span;
        return v[31:0];
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_rsp_ready();
        if (outstanding.size() == 0) return 1'b1;
        if (outstanding[0].is_load) return lsu_o_ready && agu_rsp_ready;
        return agu_rsp_ready;
    endfunction

    // Model state advances on each clock using the values just sampled.
    always @(posedge clk) begin
        bit      do_pop, do_push;
        access_t a;
        if (!rst_n) begin
            outstanding.delete();
        end else begin
            do_pop  = dtcm_rsp_valid && outstanding.size() != 0 && model_rsp_ready();
            do_push = agu_cmd_valid && dtcm_cmd_ready && outstanding.size() < c_DEPTH;
            a.tag     = int'(agu_cmd_itag);
            a.is_load = agu_cmd_read;
            a.nbytes  = size_bytes(agu_cmd_size);
            a.offset  = int'(agu_cmd_addr[1:0]);
            a.usign   = agu_cmd_usign;
            if (do_pop)  outstanding.delete(0);
            if (do_push) outstanding.push_back(a);
            if (lsu_o_valid && lsu_o_ready) wb_count++;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit full, empty, exp_lv, exp_av;
        if (mon_en) begin
            full   = outstanding.size() == c_DEPTH;
            empty  = outstanding.size() == 0;
            exp_lv = dtcm_rsp_valid && !empty && outstanding[0].is_load;
            exp_av = dtcm_rsp_valid && !empty && (!outstanding[0].is_load || lsu_o_ready);
            check("dtcm_cmd_valid", 32'(dtcm_cmd_valid), 32'(agu_cmd_valid && !full));
            check("agu_cmd_ready", 32'(agu_cmd_ready), 32'(dtcm_cmd_ready && !full));
            check("dtcm_rsp_ready", 32'(dtcm_rsp_ready), 32'(model_rsp_ready()));
            check("lsu_o_valid", 32'(lsu_o_valid), 32'(exp_lv));
            check("agu_rsp_valid", 32'(agu_rsp_valid), 32'(exp_av));
            if (agu_cmd_valid && !full) begin
                check("dtcm_cmd_addr", 32'(dtcm_cmd_addr), 32'(agu_cmd_addr));
                check("dtcm_cmd_read", 32'(dtcm_cmd_read), 32'(agu_cmd_read));
                check("dtcm_cmd_wdata", dtcm_cmd_wdata, agu_cmd_wdata);
                check("dtcm_cmd_wmask", 32'(dtcm_cmd_wmask), agu_cmd_read ? 32'd0 : 32'(agu_cmd_wmask));
            end
            if (exp_lv) begin
                check("wbck_wdat", lsu_o_wbck_wdat,
                      model_load(dtcm_rsp_rdata, outstanding[0].nbytes, outstanding[0].offset, outstanding[0].usign));
                check("wbck_itag", 32'(lsu_o_wbck_itag), 32'(outstanding[0].tag));
                check("wbck_err", 32'(lsu_o_wbck_err), 32'(dtcm_rsp_err));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] addr, input logic rd, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic [1:0] tag, input logic [1:0] sz,
                         input logic us);
        bit done = 1'b0;
        agu_cmd_valid = 1'b1; agu_cmd_addr = addr; agu_cmd_read = rd; agu_cmd_wdata = wdata;
        agu_cmd_wmask = wmask; agu_cmd_itag = tag; agu_cmd_size = sz; agu_cmd_usign = us;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (agu_cmd_ready) done = 1'b1;
            step();
        end
        agu_cmd_valid = 1'b0;
        if (!done) check("issue_timeout", 32'd0, 32'd1);
    endtask

    // Deliver one response; on its handshake cycle pin the result to literal values.
    task automatic respond(input logic [31:0] rdata, input logic err, input bit is_load,
                           input logic [31:0] exp_wdat, input logic [1:0] exp_tag);
        bit done = 1'b0;
        dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = rdata; dtcm_rsp_err = err;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (dtcm_rsp_ready) begin
                done = 1'b1;
                check("lit_agu_rsp_valid", 32'(agu_rsp_valid), 32'd1);
                check("lit_lsu_o_valid", 32'(lsu_o_valid), 32'(is_load));
                if (is_load) begin
                    check("lit_wdat", lsu_o_wbck_wdat, exp_wdat);
                    check("lit_itag", 32'(lsu_o_wbck_itag), 32'(exp_tag));
                    check("lit_err", 32'(lsu_o_wbck_err), 32'(err));
                end
            end
            step();
        end
        dtcm_rsp_valid = 1'b0; dtcm_rsp_err = 1'b0;
        if (!done) check("respond_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int wb_before;
        rst_n = 1'b0;
        agu_cmd_valid = 1'b0; agu_cmd_addr = '0; agu_cmd_read = 1'b0; agu_cmd_wdata = '0;
        agu_cmd_wmask = '0; agu_cmd_itag = '0; agu_cmd_size = '0; agu_cmd_usign = 1'b0;
        agu_rsp_ready = 1'b0; dtcm_cmd_ready = 1'b0; dtcm_rsp_valid = 1'b0;
        dtcm_rsp_rdata = '0; dtcm_rsp_err = 1'b0; lsu_o_ready = 1'b0;
        step(); step();
        @(negedge clk);
        check("rst_dtcm_rsp_ready", 32'(dtcm_rsp_ready), 32'd1);
        check("rst_outputs", {agu_cmd_ready, agu_rsp_valid, dtcm_cmd_valid, lsu_o_valid,
                              lsu_o_wbck_err, dtcm_cmd_wmask}, 32'd0);
        check("rst_wdat", lsu_o_wbck_wdat, 32'd0);
        step();
        rst_n = 1'b1; dtcm_cmd_ready = 1'b1; agu_rsp_ready = 1'b1; lsu_o_ready = 1'b1;
        mon_en = 1'b1;
        step();

        // Store word, pass-through in the same cycle.
        agu_cmd_valid = 1'b1; agu_cmd_addr = 16'h0010; agu_cmd_read = 1'b0;
        agu_cmd_wdata = 32'hDEADBEEF; agu_cmd_wmask = 4'b1111; agu_cmd_itag = 2'd0;
        agu_cmd_size = 2'b10; agu_cmd_usign = 1'b0;
        @(negedge clk);
        check("sw_cmd_valid", 32'(dtcm_cmd_valid), 32'd1);
        check("sw_wmask", 32'(dtcm_cmd_wmask), 32'hF);
        check("sw_wdata", dtcm_cmd_wdata, 32'hDEADBEEF);
        step();
        agu_cmd_valid = 1'b0;
        respond(32'h0, 1'b0, 1'b0, 32'h0, 2'd0);

        // Byte loads, signed and unsigned.
        issue(16'h0003, 1'b1, 32'h0, 4'hF, 2'd1, 2'b00, 1'b0);
        respond(32'h80123456, 1'b0, 1'b1, 32'hFFFFFF80, 2'd1);
        issue(16'h0003, 1'b1, 32'h0, 4'hF, 2'd2, 2'b00, 1'b1);
        respond(32'h80123456, 1'b0, 1'b1, 32'h00000080, 2'd2);
        issue(16'h0101, 1'b1, 32'h0, 4'hF, 2'd3, 2'b00, 1'b0);
        respond(32'h00007F00, 1'b0, 1'b1, 32'h0000007F, 2'd3);

        // Halfword and word loads.
        issue(16'h0002, 1'b1, 32'h0, 4'hF, 2'd1, 2'b01, 1'b0);
        respond(32'h80011234, 1'b0, 1'b1, 32'hFFFF8001, 2'd1);
        issue(16'h0002, 1'b1, 32'h0, 4'hF, 2'd2, 2'b01, 1'b1);
        respond(32'h80011234, 1'b0, 1'b1, 32'h00008001, 2'd2);
        issue(16'h0004, 1'b1, 32'h0, 4'hF, 2'd0, 2'b10, 1'b0);
        respond(32'h89ABCDEF, 1'b0, 1'b1, 32'h89ABCDEF, 2'd0);

        // Fill the outstanding FIFO, then response and command in the same cycle.
        issue(16'h0020, 1'b1, 32'h0, 4'hF, 2'd1, 2'b10, 1'b0);
        issue(16'h0024, 1'b1, 32'h0, 4'hF, 2'd2, 2'b10, 1'b0);
        agu_cmd_valid = 1'b1; agu_cmd_addr = 16'h0028; agu_cmd_read = 1'b1;
        agu_cmd_itag = 2'd3; agu_cmd_size = 2'b10; agu_cmd_usign = 1'b0;
        @(negedge clk);
        check("full_cmd_ready", 32'(agu_cmd_ready), 32'd0);
        check("full_cmd_valid", 32'(dtcm_cmd_valid), 32'd0);
        step();
        dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'h11111111;
        @(negedge clk);
        check("pop_only_ready", 32'(agu_cmd_ready), 32'd0);
        check("pop_only_rsp", 32'(agu_rsp_valid), 32'd1);
        check("pop_only_tag", 32'(lsu_o_wbck_itag), 32'd1);
        step();
        dtcm_rsp_valid = 1'b0;
        @(negedge clk);
        check("push_next_ready", 32'(agu_cmd_ready), 32'd1);
        step();
        agu_cmd_valid = 1'b0;
        respond(32'h22222222, 1'b0, 1'b1, 32'h22222222, 2'd2);
        respond(32'h33333333, 1'b0, 1'b1, 32'h33333333, 2'd3);

        // Writeback back-pressure holds the head entry.
        issue(16'h0030, 1'b1, 32'h0, 4'hF, 2'd2, 2'b00, 1'b1);
        wb_before = wb_count;
        lsu_o_ready = 1'b0; dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'h000000A5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_rsp_ready", 32'(dtcm_rsp_ready), 32'd0);
            check("bp_agu_rsp", 32'(agu_rsp_valid), 32'd0);
            step();
        end
        lsu_o_ready = 1'b1;
        @(negedge clk);
        check("bp_release_wdat", lsu_o_wbck_wdat, 32'h000000A5);
        step();
        dtcm_rsp_valid = 1'b0;
        step();
        check("bp_single_wb", 32'(wb_count - wb_before), 32'd1);

        // Reset with two outstanding loads, then a stale response is drained.
        issue(16'h0040, 1'b1, 32'h0, 4'hF, 2'd1, 2'b10, 1'b0);
        issue(16'h0044, 1'b1, 32'h0, 4'hF, 2'd2, 2'b10, 1'b0);
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        dtcm_rsp_valid = 1'b1; dtcm_rsp_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("stale_rsp_ready", 32'(dtcm_rsp_ready), 32'd1);
        check("stale_lsu_valid", 32'(lsu_o_valid), 32'd0);
        check("stale_agu_valid", 32'(agu_rsp_valid), 32'd0);
        step();
        dtcm_rsp_valid = 1'b0;

        // Errors: flagged on loads, stores still complete.
        issue(16'h0050, 1'b1, 32'h0, 4'hF, 2'd3, 2'b01, 1'b0);
        respond(32'h00007FFF, 1'b1, 1'b1, 32'h00007FFF, 2'd3);
        issue(16'h0051, 1'b0, 32'h5A5A5A5A, 4'b0010, 2'd0, 2'b00, 1'b0);
        respond(32'h0, 1'b1, 1'b0, 32'h0, 2'd0);

        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
